// File: rtl/pin_auth_pkg.sv
// Shared types and constants for the ATM PIN authentication front end.
package pin_auth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    SESSION = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIMER_W = 9;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [TIMER_W-1:0] TIMEOUT_DEF = 9'd300;

endpackage

// File: rtl/timeout_counter.sv
// Saturating down counter with synchronous load; zero_c flags an expired count.
module timeout_counter
  import pin_auth_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero_c
);

  // Load wins over decrement; the count holds once it reaches zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pin_auth_ctrl.sv
// Card capture, BCD PIN entry/compare, attempt lockout and session timer.
// Build option: SESSION_TIMEOUT_EN enables the Tempo timer and its timeouts.
module pin_auth_ctrl
  import pin_auth_pkg::*;
#(
  parameter int unsigned        DIGITS    = 4,
  parameter int unsigned        MAX_TRIES = 3,
  parameter logic [TIMER_W-1:0] TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned        ACCT_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      card_in,
  input  logic [ACCT_W-1:0]         acct_code,
  input  logic [DIGIT_W-1:0]        digit,
  input  logic                      digit_vld,
  input  logic [DIGIT_W*DIGITS-1:0] pin_ref,
  input  logic                      logout,
  output logic                      auth_ok,
  output logic                      locked,
  output logic                      bad_pin,
  output logic [1:0]                tries_left,
  output logic [2:0]                digit_cnt,
  output logic [ACCT_W-1:0]         acct,
  output logic [TIMER_W-1:0]        tempo
);

  localparam int unsigned ENTRY_W  = DIGIT_W * DIGITS;
  localparam logic [2:0]  LAST_IDX = 3'(DIGITS - 1);

  state_t               state, state_n;
  logic                 auth_n, locked_n, bad_n;
  logic [1:0]           tries_n;
  logic [2:0]           cnt_n;
  logic [ACCT_W-1:0]    acct_n;
  logic [ENTRY_W-1:0]   entry, entry_n;
  logic                 force_fail, force_n;
  logic                 card_q;
  logic                 tmr_load, tmr_en;
  logic                 tmo_c;
  logic                 card_rise_c, card_fall_c, digit_ok_c;

  assign card_rise_c = card_in & ~card_q;
  assign card_fall_c = ~card_in & card_q;
  assign digit_ok_c  = digit_vld && (digit <= BCD_MAX);

`ifdef SESSION_TIMEOUT_EN
  logic tmr_zero_c;

  timeout_counter u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TIMEOUT),
    .count    (tempo),
    .zero_c   (tmr_zero_c)
  );

  assign tmo_c = tmr_zero_c;
`else
  logic unused_tmr;

  assign tempo      = '0;
  assign tmo_c      = 1'b0;
  assign unused_tmr = ^{tmr_load, tmr_en, TIMEOUT};
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      auth_ok    <= 1'b0;
      locked     <= 1'b0;
      bad_pin    <= 1'b0;
      tries_left <= 2'(MAX_TRIES);
      digit_cnt  <= '0;
      acct       <= '0;
      entry      <= '0;
      force_fail <= 1'b0;
      card_q     <= 1'b0;
    end else begin
      state      <= state_n;
      auth_ok    <= auth_n;
      locked     <= locked_n;
      bad_pin    <= bad_n;
      tries_left <= tries_n;
      digit_cnt  <= cnt_n;
      acct       <= acct_n;
      entry      <= entry_n;
      force_fail <= force_n;
      card_q     <= card_in;
    end
  end

  // Next state, next outputs and timer control.
  always_comb begin
    state_n  = state;
    auth_n   = auth_ok;
    locked_n = locked;
    bad_n    = 1'b0;
    tries_n  = tries_left;
    cnt_n    = digit_cnt;
    acct_n   = acct;
    entry_n  = entry;
    force_n  = force_fail;
    tmr_load = 1'b0;
    tmr_en   = (state == ENTRY) || (state == SESSION);

    unique case (state)
      IDLE: begin
        if (card_rise_c) begin
          acct_n   = acct_code;
          cnt_n    = '0;
          entry_n  = '0;
          tmr_load = 1'b1;
          state_n  = ENTRY;
        end
      end

      ENTRY: begin
        if (card_fall_c) begin
          state_n = IDLE;
          acct_n  = '0;
          cnt_n   = '0;
          entry_n = '0;
        end else if (digit_ok_c) begin
          entry_n  = {entry[ENTRY_W-DIGIT_W-1:0], digit};
          cnt_n    = digit_cnt + 3'd1;
          tmr_load = 1'b1;
          if (digit_cnt == LAST_IDX) begin
            state_n = CHECK;
            force_n = 1'b0;
          end
        end else if (tmo_c) begin
          // Expired entry is scored as a failed attempt.
          state_n = CHECK;
          force_n = 1'b1;
        end
      end

      CHECK: begin
        if (card_fall_c) begin
          state_n = IDLE;
          acct_n  = '0;
          cnt_n   = '0;
          entry_n = '0;
        end else if (!force_fail && (entry == pin_ref)) begin
          state_n  = SESSION;
          auth_n   = 1'b1;
          tries_n  = 2'(MAX_TRIES);
          tmr_load = 1'b1;
        end else begin
          bad_n = 1'b1;
          if (tries_left <= 2'd1) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            tries_n  = '0;
          end else begin
            tries_n  = tries_left - 2'd1;
            state_n  = ENTRY;
            cnt_n    = '0;
            entry_n  = '0;
            tmr_load = 1'b1;
          end
        end
      end

      SESSION: begin
        if (logout || card_fall_c || tmo_c) begin
          state_n = IDLE;
          auth_n  = 1'b0;
          acct_n  = '0;
          cnt_n   = '0;
        end
      end

      LOCKED: begin
        locked_n = 1'b1;
        auth_n   = 1'b0;
        tries_n  = '0;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pin_auth_ctrl.sv
// Self-checking bench for pin_auth_ctrl: vector table, directed corner cases, random vs model.
module tb_pin_auth_ctrl;

  localparam int unsigned TO  = 20;
  localparam logic [15:0] PIN = 16'h1234;
`ifdef SESSION_TIMEOUT_EN
  localparam bit TMR_ON = 1'b1;
`else
  localparam bit TMR_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_SESS = 3, M_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        card_in, digit_vld, logout;
  logic [4:0]  acct_code;
  logic [3:0]  digit;
  logic [15:0] pin_ref;
  logic        auth_ok, locked, bad_pin;
  logic [1:0]  tries_left;
  logic [2:0]  digit_cnt;
  logic [4:0]  acct;
  logic [8:0]  tempo;

  int checks   = 0;
  int failures = 0;

  pin_auth_ctrl #(
    .DIGITS(4), .MAX_TRIES(3), .TIMEOUT(9'(TO)), .ACCT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .acct_code(acct_code),
    .digit(digit), .digit_vld(digit_vld), .pin_ref(pin_ref), .logout(logout),
    .auth_ok(auth_ok), .locked(locked), .bad_pin(bad_pin),
    .tries_left(tries_left), .digit_cnt(digit_cnt), .acct(acct), .tempo(tempo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: session phase, entered digits as a list, expected outputs.
  int m_ph;
  bit m_card_q, m_force;
  int m_digits[$];
  bit e_auth, e_lock, e_bad;
  int e_tries, e_cnt, e_acct, e_tempo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = M_IDLE; m_card_q = 0; m_force = 0; m_digits.delete();
    e_auth = 0; e_lock = 0; e_bad = 0; e_tries = 3; e_cnt = 0; e_acct = 0; e_tempo = 0;
  endtask

  task automatic drop_card();
    m_ph = M_IDLE; e_acct = 0; e_cnt = 0; m_digits.delete();
  endtask

  function automatic int pin_val();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic model_step();
    bit fall, rise, tmo, good;
    int nt;
    fall = m_card_q && !card_in;
    rise = !m_card_q && card_in;
    tmo  = TMR_ON && (e_tempo == 0);
    good = digit_vld && (digit <= 4'd9);
    nt = e_tempo;
    if ((m_ph == M_ENTRY || m_ph == M_SESS) && nt > 0) nt--;
    e_bad = 0;
    case (m_ph)
      M_IDLE:
        if (rise) begin
          e_acct = int'(acct_code); e_cnt = 0; nt = TO; m_digits.delete(); m_ph = M_ENTRY;
        end
      M_ENTRY:
        if (fall) drop_card();
        else if (good) begin
          m_digits.push_back(int'(digit)); e_cnt++; nt = TO;
          if (e_cnt == 4) begin m_ph = M_CHECK; m_force = 0; end
        end else if (tmo) begin
          m_ph = M_CHECK; m_force = 1;
        end
      M_CHECK:
        if (fall) drop_card();
        else if (!m_force && pin_val() == int'(pin_ref)) begin
          m_ph = M_SESS; e_auth = 1; e_tries = 3; nt = TO;
        end else begin
          e_bad = 1; e_tries--;
          if (e_tries == 0) begin
            m_ph = M_LOCK; e_lock = 1;
          end else begin
            m_ph = M_ENTRY; e_cnt = 0; m_digits.delete(); nt = TO;
          end
        end
      M_SESS:
        if (logout || fall || tmo) begin
          m_ph = M_IDLE; e_auth = 0; e_acct = 0; e_cnt = 0;
        end
      default: ;
    endcase
    e_tempo  = TMR_ON ? nt : 0;
    m_card_q = card_in;
  endtask

  task automatic cmp_model();
    chk("auth_ok", auth_ok, e_auth);
    chk("locked", locked, e_lock);
    chk("bad_pin", bad_pin, e_bad);
    chk("tries_left", tries_left, e_tries);
    chk("digit_cnt", digit_cnt, e_cnt);
    chk("acct", acct, e_acct);
    chk("tempo", tempo, e_tempo);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic drive(input logic c, input logic [3:0] d, input logic v, input logic lo);
    card_in = c; digit = d; digit_vld = v; logout = lo;
  endtask

  task automatic enter(input logic [15:0] p);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, p[15-4*k -: 4], 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    m_reset();
    #1 cmp_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic card; logic [3:0] dg; logic vld; logic lo;
    logic ea; logic el; logic eb; logic [1:0] et; logic [2:0] ec; logic [4:0] eacct;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input logic card, input logic [3:0] dg, input logic vld, input logic lo,
                      input logic ea, input logic el, input logic eb,
                      input logic [1:0] et, input logic [2:0] ec, input logic [4:0] eacct);
    vec_t v;
    v.card = card; v.dg = dg; v.vld = vld; v.lo = lo;
    v.ea = ea; v.el = el; v.eb = eb; v.et = et; v.ec = ec; v.eacct = eacct;
    tv.push_back(v);
  endtask

  initial begin
    int n;
    logic [3:0] d;
    rst = 1'b1; pin_ref = PIN; acct_code = 5'h1F;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    m_reset();
    #3 cmp_model();
    @(negedge clk);
    rst = 1'b0;

    // Correct PIN, session, logout; then three wrong PINs to lock.
    addv(1, 4'd7, 1, 0, 0, 0, 0, 2'd3, 3'd0, 5'h1F);
    addv(1, 4'd1, 1, 0, 0, 0, 0, 2'd3, 3'd1, 5'h1F);
    addv(1, 4'd2, 1, 0, 0, 0, 0, 2'd3, 3'd2, 5'h1F);
    addv(1, 4'hA, 1, 0, 0, 0, 0, 2'd3, 3'd2, 5'h1F);
    addv(1, 4'd3, 1, 0, 0, 0, 0, 2'd3, 3'd3, 5'h1F);
    addv(1, 4'd4, 1, 0, 0, 0, 0, 2'd3, 3'd4, 5'h1F);
    addv(1, 4'd0, 0, 0, 1, 0, 0, 2'd3, 3'd4, 5'h1F);
    addv(1, 4'd5, 1, 0, 1, 0, 0, 2'd3, 3'd4, 5'h1F);
    addv(1, 4'd0, 0, 1, 0, 0, 0, 2'd3, 3'd0, 5'h00);
    addv(0, 4'd0, 0, 0, 0, 0, 0, 2'd3, 3'd0, 5'h00);
    addv(1, 4'd0, 0, 0, 0, 0, 0, 2'd3, 3'd0, 5'h1F);
    for (int a = 0; a < 3; a++) begin
      addv(1, 4'd1, 1, 0, 0, 0, 0, 2'(3 - a), 3'd1, 5'h1F);
      addv(1, 4'd2, 1, 0, 0, 0, 0, 2'(3 - a), 3'd2, 5'h1F);
      addv(1, 4'd3, 1, 0, 0, 0, 0, 2'(3 - a), 3'd3, 5'h1F);
      addv(1, 4'd5, 1, 0, 0, 0, 0, 2'(3 - a), 3'd4, 5'h1F);
      addv(1, 4'd0, 0, 0, 0, (a == 2), 1, 2'(2 - a), (a == 2) ? 3'd4 : 3'd0, 5'h1F);
    end
    addv(0, 4'd0, 0, 0, 0, 1, 0, 2'd0, 3'd4, 5'h1F);
    addv(1, 4'd1, 1, 0, 0, 1, 0, 2'd0, 3'd4, 5'h1F);
    addv(1, 4'd0, 0, 1, 0, 1, 0, 2'd0, 3'd4, 5'h1F);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].card, tv[i].dg, tv[i].vld, tv[i].lo);
      tick();
      chk($sformatf("tv%0d.auth_ok", i), auth_ok, tv[i].ea);
      chk($sformatf("tv%0d.locked", i), locked, tv[i].el);
      chk($sformatf("tv%0d.bad_pin", i), bad_pin, tv[i].eb);
      chk($sformatf("tv%0d.tries_left", i), tries_left, tv[i].et);
      chk($sformatf("tv%0d.digit_cnt", i), digit_cnt, tv[i].ec);
      chk($sformatf("tv%0d.acct", i), acct, tv[i].eacct);
    end

    drive(1'b0, 4'd0, 1'b0, 1'b0);
    apply_reset();
    chk("unlock.locked", locked, 0);
    chk("unlock.tries_left", tries_left, 3);

    // Logout and card removal together in SESSION give one exit.
    acct_code = 5'h0A;
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    enter(PIN);
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    chk("race.auth_on", auth_ok, 1);
    drive(1'b0, 4'd0, 1'b0, 1'b1); tick();
    chk("race.auth_off", auth_ok, 0);
    chk("race.acct", acct, 0);
    drive(1'b0, 4'd0, 1'b0, 1'b0); tick();
    chk("race.idle_auth", auth_ok, 0);
    chk("race.idle_bad", bad_pin, 0);
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    chk("race.reinsert_acct", acct, 5'h0A);

    // Async reset mid-entry restores attempts without a clock edge.
    enter(16'h9999);
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    chk("ar.bad_pin", bad_pin, 1);
    chk("ar.tries_before", tries_left, 2);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 4'(k), 1'b1, 1'b0); tick();
    end
    chk("ar.cnt3", digit_cnt, 3);
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar.auth_ok", auth_ok, 0);
    chk("ar.locked", locked, 0);
    chk("ar.bad_pin_rst", bad_pin, 0);
    chk("ar.digit_cnt", digit_cnt, 0);
    chk("ar.acct", acct, 0);
    chk("ar.tempo", tempo, 0);
    chk("ar.tries_left", tries_left, 3);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar.insert_on_release", acct, 5'h0A);

`ifdef SESSION_TIMEOUT_EN
    // Entry timeout: two digits then silence.
    drive(1'b0, 4'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    chk("to.load", tempo, TO);
    drive(1'b1, 4'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 4'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    n = 0;
    while (bad_pin !== 1'b1 && n < 40) begin tick(); n++; end
    chk("to.entry_latency", n, 22);
    chk("to.tries_left", tries_left, 2);
    chk("to.digit_cnt", digit_cnt, 0);
    // Invalid digit keeps the timer running; a digit at tempo==1 wins.
    drive(1'b1, 4'hA, 1'b1, 1'b0); tick();
    chk("inv.cnt", digit_cnt, 0);
    chk("inv.tempo", tempo, TO - 1);
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    repeat (18) tick();
    chk("edge.tempo1", tempo, 1);
    drive(1'b1, 4'd7, 1'b1, 1'b0); tick();
    chk("edge.reload", tempo, TO);
    chk("edge.cnt", digit_cnt, 1);
    chk("edge.no_fail", bad_pin, 0);
    // Session timeout.
    drive(1'b0, 4'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    enter(PIN);
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    chk("sto.auth_on", auth_ok, 1);
    chk("sto.tries", tries_left, 3);
    n = 0;
    while (auth_ok === 1'b1 && n < 40) begin tick(); n++; end
    chk("sto.latency", n, 21);
    chk("sto.acct", acct, 0);
`else
    // Without the timer, entry waits indefinitely.
    drive(1'b0, 4'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 4'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    repeat (400) tick();
    chk("nt.tempo", tempo, 0);
    chk("nt.cnt", digit_cnt, 1);
    chk("nt.tries", tries_left, 3);
`endif

    // Randomized traffic against the model.
    drive(1'b0, 4'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 1500; i++) begin
      if (e_lock && $urandom_range(0, 15) == 0) apply_reset();
      if ($urandom_range(0, 39) == 0) card_in = ~card_in;
      if (e_cnt < 4 && $urandom_range(0, 1) == 1)
        d = 4'((pin_ref >> (4 * (3 - e_cnt))) & 16'hF);
      else
        d = 4'($urandom_range(0, 11));
      digit     = d;
      digit_vld = ($urandom_range(0, 2) == 0);
      logout    = ($urandom_range(0, 29) == 0);
      acct_code = 5'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pin_auth_ctrl.md
Name: pin_auth_ctrl

Overview:
Upstream stage of the ATM datapath (balance/withdrawal schematic with VAL/SALDO displays). It captures the account code on card insertion, collects a 4-digit BCD PIN one digit at a time and compares it against the reference PIN. It counts failed attempts, locks the card after MAX_TRIES failures, and runs the 9-bit session timer shown as Tempo. auth_ok is the enable consumed by the downstream transaction stage.

Parameters:
DIGITS, 4, PIN length in BCD digits (entry register width = 4*DIGITS)
MAX_TRIES, 3, failed attempts before lock (1..3)
TIMEOUT, 9'd300, timer reload value in clk cycles (1..511)
ACCT_W, 5, account code width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
card_in  in  1  card present level (drives ENABLE path)
acct_code  in  ACCT_W  account code (COD), sampled on card insertion
digit  in  4  BCD digit from keypad
digit_vld  in  1  one-cycle digit strobe
pin_ref  in  4*DIGITS  expected PIN, first digit in MSB nibble
logout  in  1  one-cycle pulse, ends session
auth_ok  out  1  session authorised (level)
locked  out  1  card locked (level, sticky until rst)
bad_pin  out  1  one-cycle pulse per failed attempt
tries_left  out  2  remaining attempts
digit_cnt  out  3  digits entered so far
acct  out  ACCT_W  latched account code
tempo  out  9  remaining timer value (Tempo)

Behaviour:
- Reset (async, rst=1): state IDLE; auth_ok=0, locked=0, bad_pin=0, digit_cnt=0, acct=0, tempo=0, tries_left=MAX_TRIES; entry register and card_in history flop cleared. A card already present at reset release is therefore seen as an insertion on the first clk edge.
- States: IDLE, ENTRY, CHECK, SESSION, LOCKED. All outputs are registered.
- IDLE: on card_in rising edge: latch acct_code into acct, digit_cnt=0, tempo=TIMEOUT, go ENTRY. digit_vld is ignored in IDLE, including in the insertion cycle.
- ENTRY:
  - digit_vld with digit<=9: shift digit into entry register (LSB nibble), digit_cnt+1, tempo=TIMEOUT.
  - digit_vld with digit>9: ignored. No count, no timer reload.
  - When the DIGITS-th valid digit is accepted at edge N, state is CHECK for cycle N+1.
- CHECK (exactly 1 cycle):
  - Match: go SESSION. auth_ok=1 from edge N+2. tries_left=MAX_TRIES. tempo=TIMEOUT.
  - Mismatch: bad_pin=1 for one cycle; tries_left-1. If the result is 0, go LOCKED. Otherwise go ENTRY with digit_cnt=0, entry register cleared, tempo=TIMEOUT.
- SESSION:
  - auth_ok=1; digit_vld ignored.
  - Exit to IDLE on any of: logout, card_in falling edge, tempo==0. On exit: auth_ok=0, acct=0, digit_cnt=0.
  - Simultaneous exit causes give the same single exit.
- LOCKED: locked=1, auth_ok=0, tries_left=0. All inputs except rst are ignored; card removal does not clear the lock.
- Card removal in ENTRY or CHECK: go IDLE, entry discarded, acct=0. tries_left is kept, so reinsertion does not restore attempts. Only a successful PIN or rst restores them.
- Timer:
  - Decrements by 1 per clk in ENTRY and SESSION; saturates at 0; held in IDLE, CHECK and LOCKED.
  - tempo reaching 0 in ENTRY is a failed attempt: goes through CHECK with a forced mismatch.
  - A valid digit_vld in the same cycle that tempo==1 wins: tempo is reloaded and there is no timeout.
- Arithmetic: tries_left and digit_cnt never wrap; the compare is a full-width equality on 4*DIGITS bits.

Optional Feature:
SESSION_TIMEOUT_EN
- Defined: timer behaves as above.
- Undefined: tempo is held at 0 and never causes a timeout or forced failure. The timeout_counter instance is not built, and ENTRY/SESSION wait indefinitely.

Decomposition:
- Package pin_auth_pkg holds:
  - state enum {IDLE, ENTRY, CHECK, SESSION, LOCKED}
  - BCD_MAX=4'd9
  - DIGIT_W=4
  - TIMER_W=9
  - default TIMEOUT
- One sub-module, timeout_counter: TIMER_W down counter with load, enable and zero flag, saturating at 0. It is instantiated only under SESSION_TIMEOUT_EN.

Test Plan:
- Correct PIN: pin_ref=16'h1234, TIMEOUT=20. Insert card with acct_code=5'b11111, enter 1,2,3,4 → acct=5'h1F; digit_cnt reaches 4; auth_ok=1 two edges after the 4th strobe; tries_left=3.
- Wrong PIN to lock: enter 1,2,3,5 three times → bad_pin pulses 3 times; tries_left 2,1,0; locked=1. Card removal and reinsertion leave locked=1 and auth_ok=0 until rst.
- Invalid digits and ignored strobes: digit=4'hA mid-entry → digit_cnt unchanged and tempo keeps decrementing. A strobe in the insertion cycle is ignored.
- Timeouts (SESSION_TIMEOUT_EN, TIMEOUT=20):
  - Enter 2 digits, then idle 20 cycles → bad_pin pulse, tries_left=2, digit_cnt=0.
  - In SESSION, idle 20 cycles → auth_ok falls and acct=0.
- Exit and boundary races: logout and card_in fall in the same cycle in SESSION → single exit to IDLE. A digit on the cycle tempo==1 → tempo=20 and no failure.
- Async reset: assert rst mid-ENTRY with 3 digits entered → all outputs return to reset values immediately, without waiting for a clk edge; tries_left=3.
